// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types for the nibble-serial CLA adder.
// Holds the sequencer state encoding and the slice width.
package cla_nibble_sequencer_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cla_nibble_sequencer_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Ports: a, b, cin in; sum, cout, c3 (carry into bit 3) out.
module cla4_slice
  import cla_nibble_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry flattened from c[i+1] = g[i] | p[i] & c[i]
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// WIDTH-bit adder feeding one nibble per cycle through a 4-bit CLA.
// Ports: clk, rst, in_valid/in_ready + a, b, carry_in; out_valid/
// out_ready + sum, carry_out, ovf; busy while RUN or DONE.
module cla_nibble_sequencer
  import cla_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_chk
      $error("WIDTH must be a nonzero multiple of 4");
    end
  endgenerate

  seq_state_t state;
  seq_state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             c_reg;
  logic [IDX_W-1:0] idx;

  logic [NIB_W-1:0] s_sum;
  logic             s_cout;
  logic             s_c3;
  logic             accept;
  logic             last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDX_W'(NIB - 1));

  cla4_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (c_reg),
    .sum  (s_sum),
    .cout (s_cout),
    .c3   (s_c3)
  );

  // New nibble enters at the top; after NIB shifts the
  // first (LSB) nibble has reached bit 0.
  assign sum_nxt = (sum_sh >> NIB_W)
                 | (WIDTH'(s_sum) << (WIDTH - NIB_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      c_reg     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= carry_in;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> NIB_W;
      b_sh   <= b_sh >> NIB_W;
      sum_sh <= sum_nxt;
      c_reg  <= s_cout;
      idx    <= idx + 1'b1;
      if (last) begin
        sum       <= sum_nxt;
        carry_out <= s_cout;
        ovf       <= s_c3 ^ s_cout;
      end
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=16 and 4).
// Random and directed adds checked against an arithmetic model.
module tb_cla_nibble_sequencer;

  logic clk;
  logic rst;

  logic        in_valid16, in_ready16, cin16;
  logic [15:0] a16, b16, sum16;
  logic        out_valid16, out_ready16;
  logic        cout16, ovf16, busy16;

  logic        in_valid4, in_ready4, cin4;
  logic [3:0]  a4, b4, sum4;
  logic        out_valid4, out_ready4;
  logic        cout4, ovf4, busy4;

  int errors = 0;
  int checks = 0;

  cla_nibble_sequencer #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .carry_in  (cin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .carry_out (cout16),
    .ovf       (ovf16),
    .busy      (busy16)
  );

  cla_nibble_sequencer #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .carry_in  (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .carry_out (cout4),
    .ovf       (ovf4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Plain integer addition; overflow from operand/result signs.
  function automatic void model(input int w,
                                input logic [31:0] x,
                                input logic [31:0] y,
                                input logic ci,
                                output logic [31:0] s,
                                output logic co,
                                output logic ov);
    logic [32:0] t;
    logic [31:0] m;
    m  = (32'h1 << w) - 32'h1;
    t  = {1'b0, x & m} + {1'b0, y & m} + 33'(ci);
    s  = t[31:0] & m;
    co = t[w];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add16(input logic [15:0] x,
                       input logic [15:0] y,
                       input logic ci,
                       input int hold);
    int n;
    int lat;
    logic [31:0] es;
    logic ec, eo;
    n = 0;
    while (!in_ready16 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready16_idle", 32'(in_ready16), 32'd1);
    a16 = x; b16 = y; cin16 = ci;
    in_valid16 = 1'b1;
    out_ready16 = (hold == 0);
    tick();
    in_valid16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency16", 32'(lat), 32'd4);
    model(16, 32'(x), 32'(y), ci, es, ec, eo);
    check("sum16", 32'(sum16), es);
    check("carry_out16", 32'(cout16), 32'(ec));
    check("ovf16", 32'(ovf16), 32'(eo));
    repeat (hold) tick();
    if (hold > 0)
      check("held_valid16", 32'(out_valid16), 32'd1);
    out_ready16 = 1'b1;
    tick();
    check("in_ready_after16", 32'(in_ready16), 32'd1);
    check("out_valid_clr16", 32'(out_valid16), 32'd0);
    check("sum_kept16", 32'(sum16), es);
  endtask

  task automatic add4(input logic [3:0] x,
                      input logic [3:0] y,
                      input logic ci);
    int lat;
    logic [31:0] es;
    logic ec, eo;
    a4 = x; b4 = y; cin4 = ci;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency4", 32'(lat), 32'd1);
    model(4, 32'(x), 32'(y), ci, es, ec, eo);
    check("sum4", 32'(sum4), es);
    check("carry_out4", 32'(cout4), 32'(ec));
    check("ovf4", 32'(ovf4), 32'(eo));
    tick();
    check("in_ready4", 32'(in_ready4), 32'd1);
  endtask

  initial begin
    logic [15:0] xs [3];
    logic [15:0] ys [3];
    logic        cs [3];
    int          acc [3];
    logic [15:0] held;
    logic [31:0] es;
    logic        ec, eo, seen;
    int k, r, cyc;
    bit will_acc;

    rst = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    out_ready16 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    out_ready4 = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_sum", 32'(sum16), 32'd0);
    check("rst_cout", 32'(cout16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    rst = 1'b0;
    tick();

    add16(16'h1234, 16'h4321, 1'b1, 0);
    add16(16'hFFFF, 16'h0001, 1'b0, 0);
    add16(16'h7FFF, 16'h0001, 1'b0, 0);
    add16(16'h8000, 16'h8000, 1'b0, 0);
    for (int i = 0; i < 25; i++)
      add16(16'($urandom), 16'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));

    // Back-pressure with ignored operands during DONE.
    out_ready16 = 1'b0;
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b0;
    in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    k = 0;
    while (!out_valid16 && k < 20) begin
      tick();
      k++;
    end
    check("bp_latency", 32'(k), 32'd4);
    check("bp_sum", 32'(sum16), 32'h0000BCDE);
    held = sum16;
    for (int i = 0; i < 10; i++) begin
      in_valid16 = 1'b1;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      tick();
      check("bp_valid", 32'(out_valid16), 32'd1);
      check("bp_in_ready", 32'(in_ready16), 32'd0);
      check("bp_sum_stable", 32'(sum16), 32'(held));
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    tick();
    check("bp_release_ready", 32'(in_ready16), 32'd1);
    check("bp_release_valid", 32'(out_valid16), 32'd0);

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 3; i++) begin
      xs[i] = 16'($urandom);
      ys[i] = 16'($urandom) | 16'h0100;
      cs[i] = 1'($urandom);
    end
    k = 0; r = 0; cyc = 0;
    a16 = xs[0]; b16 = ys[0]; cin16 = cs[0];
    in_valid16 = 1'b1;
    while (r < 3 && cyc < 100) begin
      will_acc = in_ready16 && in_valid16;
      if (out_valid16) begin
        model(16, 32'(xs[r]), 32'(ys[r]), cs[r],
              es, ec, eo);
        check("b2b_sum", 32'(sum16), es);
        check("b2b_cout", 32'(cout16), 32'(ec));
        check("b2b_ovf", 32'(ovf16), 32'(eo));
        check("b2b_latency", 32'(cyc - acc[r]), 32'd4);
        r++;
      end
      tick();
      cyc++;
      if (will_acc) begin
        acc[k] = cyc;
        k++;
        if (k < 3) begin
          a16 = xs[k]; b16 = ys[k]; cin16 = cs[k];
        end else begin
          in_valid16 = 1'b0;
        end
      end
    end
    in_valid16 = 1'b0;
    check("b2b_count", 32'(r), 32'd3);
    tick();

    // Reset in the second RUN cycle.
    add16(16'h1357, 16'h2468, 1'b0, 0);
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0;
    in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready16), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid16), 32'd0);
    check("mid_rst_busy", 32'(busy16), 32'd0);
    check("mid_rst_sum", 32'(sum16), 32'd0);
    check("mid_rst_cout", 32'(cout16), 32'd0);
    check("mid_rst_ovf", 32'(ovf16), 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid16) seen = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);
    add16(16'h0003, 16'h0004, 1'b0, 0);

    // Narrow instance: single RUN cycle.
    add4(4'hF, 4'h1, 1'b0);
    add4(4'h7, 4'h1, 1'b0);
    for (int i = 0; i < 8; i++)
      add4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
